datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs memtoreg, regdst, iord, alusrca, irwrite, pcen, regwrite, immext  in  1 each  control strobes from controller.
REQ-004 SHALL have inputs pcsrc  in  2, alusrcb  in  2, alucontrol  in  3  mux and ALU selects.
REQ-005 SHALL have input readdata  in  32  memory read data, valid in the same cycle as adr.
REQ-006 SHALL have outputs adr  out  32, writedata  out  32  memory address and store data.
REQ-007 SHALL have outputs opcode  out  6 (instr[31:26]), funct  out  6 (instr[5:0]), zero  out  1 (ALU result == 0)  to controller.

Function
REQ-008 SHALL hold architectural registers PC, Instr, Data, A, B, ALUOut (32 bits each) and a 32x32 register file.
REQ-009 SHALL load PC on each rising edge where pcen=1, and hold it otherwise.
REQ-010 SHALL load Instr from readdata on each edge where irwrite=1, and hold it otherwise.
REQ-011 SHALL load Data, A, B and ALUOut on every edge, with no enable.
REQ-012 SHALL drive adr = iord ? ALUOut : PC and writedata = B, combinationally.
REQ-013 SHALL select SrcA = alusrca ? A : PC.
REQ-014 SHALL select SrcB as: 00 -> B; 01 -> 32'd4; 10 -> ImmExt; 11 -> ImmExt<<2.
REQ-015 SHALL form ImmExt as immext=1 -> zero-extend instr[15:0], immext=0 -> sign-extend instr[15:0].
REQ-016 SHALL compute alucontrol as 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 0/1); any other code yields 32'd0.
REQ-017 SHALL wrap add and sub modulo 2^32, with no overflow flag.
REQ-018 SHALL select next PC as: pcsrc 00 -> ALUResult; 01 -> ALUOut; 10 -> {PC[31:28], instr[25:0], 2'b00}; 11 -> ALUResult.
REQ-019 SHALL read register-file ports at instr[25:21] into A and instr[20:16] into B, asynchronously.
REQ-020 SHALL write the register file on the clock edge where regwrite=1: address regdst ? instr[15:11] : instr[20:16]; data memtoreg ? Data : ALUOut.
REQ-021 SHALL always read register 0 as 0 and discard writes to it.
REQ-022 SHALL, when a same-cycle read and write hit one register, return the old value on the read; the new value is visible next cycle.
REQ-023 SHALL, on pcen and irwrite asserted together, capture Instr from readdata at the old PC while PC takes its new value.

Reset
REQ-024 SHALL, while reset=1, force PC, Instr, Data, A, B, ALUOut and all 32 register-file entries to 0, independent of clk.
REQ-025 SHALL drive, after reset, adr=0, opcode=0, funct=0 and writedata=0.
REQ-026 SHALL, on reset asserted mid-instruction, abandon the instruction; no register-file write completes on an edge where reset=1.

Configuration
REQ-027 SHALL, when DATAPATH_DBG_EN is defined, add input dbg_ra (5) and output dbg_rd (32) as a third asynchronous register-file read port, with dbg_ra=0 returning 0.
REQ-028 SHALL, when DATAPATH_DBG_EN is undefined, omit both ports with no other behavioural change.

Structure
REQ-029 SHALL take the ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT) and the pcsrc/alusrcb select encodings from a shared package, mips_pkg, also used by the controller decoders.
REQ-030 SHALL implement the register file as one sub-module, regfile (two read ports plus the optional debug port, one write port); the ALU, muxes and registers stay inline.

Verification
REQ-031 Bench SHALL check: reset pulse mid-run -> PC=0, adr=0, opcode=0, and reg file x5 reads 0.
REQ-032 Bench SHALL check: fetch with readdata=32'h20080005, irwrite=1, pcen=1, alusrcb=01, pcsrc=00 -> Instr=32'h20080005, PC 0->4, opcode=6'h08.
REQ-033 Bench SHALL check: instr[15:0]=16'hFFFC with alusrcb=10 -> immext=0 gives SrcB=32'hFFFFFFFC, immext=1 gives 32'h0000FFFC.
REQ-034 Bench SHALL check: A=5, B=7 -> alucontrol 110 gives ALUResult=32'hFFFFFFFE with zero=0; 111 gives 1; with A=B=7, 110 gives zero=1.
REQ-035 Bench SHALL check: regwrite=1 to rd=0 with ALUOut=32'hDEAD -> $0 still reads 0; the same write to rd=9 makes $9 read 32'hDEAD next cycle, not the same cycle.
REQ-036 Bench SHALL check: pcsrc=10 with PC=32'h40000010 and instr[25:0]=26'h0000100 -> new PC=32'h40000400.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle encodings: ALU opcodes and mux select codes.
// Used by the datapath and the controller decoders.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_ALU_B  = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // zext=1 zero-extends, zext=0 sign-extends a 16-bit immediate
  function automatic logic [31:0] ext16(
    input logic [15:0] imm,
    input logic        zext
  );
    logic fill;
    fill = zext ? 1'b0 : imm[15];
    return {{16{fill}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// Optional debug read port when DATAPATH_DBG_EN is defined.
module regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef DATAPATH_DBG_EN
  input  logic [4:0]  dbg_ra,
  output logic [31:0] dbg_rd,
`endif
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];

  // clear on reset; writes to $0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  // asynchronous reads, $0 hardwired to zero
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];
  end

`ifdef DATAPATH_DBG_EN
  // debug read port, same rules as the main ports
  always_comb begin
    dbg_rd = (dbg_ra == 5'd0) ? 32'd0 : mem[dbg_ra];
  end
`endif

endmodule

// File: rtl/datapath.sv
// Multicycle MIPS datapath: PC, IR, staging regs, ALU, muxes.
// Define DATAPATH_DBG_EN for a debug register-file read port.
module datapath
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef DATAPATH_DBG_EN
  input  logic [4:0]  dbg_ra,
  output logic [31:0] dbg_rd,
`endif
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic        iord,
  input  logic        alusrca,
  input  logic        irwrite,
  input  logic        pcen,
  input  logic        regwrite,
  input  logic        immext,
  input  logic [1:0]  pcsrc,
  input  logic [1:0]  alusrcb,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        zero
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] data;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;

  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] pc_next;
  logic [31:0] wd3;
  logic [4:0]  wa3;

  regfile u_rf (
    .clk   (clk),
    .reset (reset),
`ifdef DATAPATH_DBG_EN
    .dbg_ra(dbg_ra),
    .dbg_rd(dbg_rd),
`endif
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (wa3),
    .wd    (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // PC and IR load on their enables; staging regs every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      instr   <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (pcen)    pc    <= pc_next;
      if (irwrite) instr <= readdata;
      data    <= readdata;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  end

  // operand selection and register-file write steering
  always_comb begin
    imm_ext = ext16(instr[15:0], immext);
    src_a   = alusrca ? a : pc;
    src_b   = b;
    unique case (alusrcb)
      SRCB_REG:    src_b = b;
      SRCB_FOUR:   src_b = 32'd4;
      SRCB_IMM:    src_b = imm_ext;
      SRCB_IMM_SH: src_b = {imm_ext[29:0], 2'b00};
      default:     src_b = b;
    endcase
    wa3 = regdst ? instr[15:11] : instr[20:16];
    wd3 = memtoreg ? data : alu_out;
  end

  // ALU; unlisted codes produce zero
  always_comb begin
    alu_result = 32'd0;
    case (alucontrol)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  // next-PC selection
  always_comb begin
    pc_next = alu_result;
    unique case (pcsrc)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[31:28], instr[25:0], 2'b00};
      PCSRC_ALU_B:  pc_next = alu_result;
      default:      pc_next = alu_result;
    endcase
  end

  // outputs to memory and controller
  always_comb begin
    adr       = iord ? alu_out : pc;
    writedata = b;
    opcode    = instr[31:26];
    funct     = instr[5:0];
    zero      = (alu_result == 32'd0);
  end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the multicycle datapath.
// Observes the DUT through its ports only.
module tb_datapath;

  logic        clk;
  logic        reset;
  logic        memtoreg, regdst, iord, alusrca;
  logic        irwrite, pcen, regwrite, immext;
  logic [1:0]  pcsrc, alusrcb;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [31:0] adr, writedata;
  logic [5:0]  opcode, funct;
  logic        zero;
`ifdef DATAPATH_DBG_EN
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
`endif

  int tests;
  int fails;

  datapath dut (
    .clk       (clk),
    .reset     (reset),
`ifdef DATAPATH_DBG_EN
    .dbg_ra    (dbg_ra),
    .dbg_rd    (dbg_rd),
`endif
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .iord      (iord),
    .alusrca   (alusrca),
    .irwrite   (irwrite),
    .pcen      (pcen),
    .regwrite  (regwrite),
    .immext    (immext),
    .pcsrc     (pcsrc),
    .alusrcb   (alusrcb),
    .alucontrol(alucontrol),
    .readdata  (readdata),
    .adr       (adr),
    .writedata (writedata),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // write v into register r via Data and memtoreg
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    readdata = {6'd0, 5'd0, r, 16'd0};
    irwrite  = 1'b1;
    step();
    irwrite  = 1'b0;
    readdata = v;
    step();
    regwrite = 1'b1;
    memtoreg = 1'b1;
    regdst   = 1'b0;
    step();
    regwrite = 1'b0;
    memtoreg = 1'b0;
  endtask

  // load Instr, then one more edge so A/B follow its fields
  task automatic seti(input logic [31:0] ins);
    readdata = ins;
    irwrite  = 1'b1;
    step();
    irwrite  = 1'b0;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    memtoreg = 0; regdst = 0; iord = 0; alusrca = 0;
    irwrite = 0; pcen = 0; regwrite = 0; immext = 0;
    pcsrc = 2'b00; alusrcb = 2'b00; alucontrol = 3'b000;
    readdata = '0;
`ifdef DATAPATH_DBG_EN
    dbg_ra = 5'd9;
`endif
    step();
    step();
    check("rst_adr", adr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);
    check("rst_funct", {26'd0, funct}, 32'h0);
    check("rst_wdata", writedata, 32'h0);
    check("rst_zero", {31'd0, zero}, 32'h1);
    reset = 1'b0;

    // fetch: Instr from old PC, PC 0 -> 4
    readdata   = 32'h20080005;
    irwrite    = 1'b1;
    pcen       = 1'b1;
    alusrca    = 1'b0;
    alusrcb    = 2'b01;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    step();
    irwrite = 1'b0;
    pcen    = 1'b0;
    check("fetch_pc", adr, 32'h4);
    check("fetch_opcode", {26'd0, opcode}, 32'h08);
    check("fetch_funct", {26'd0, funct}, 32'h05);

    // immediate extension, observed through ALUOut with A=0
    readdata = 32'h0000FFFC;
    irwrite  = 1'b1;
    step();
    irwrite  = 1'b0;
    alusrca  = 1'b1;
    alusrcb  = 2'b10;
    immext   = 1'b0;
    step();
    iord = 1'b1;
    #1;
    check("imm_sext", adr, 32'hFFFFFFFC);
    immext = 1'b1;
    step();
    check("imm_zext", adr, 32'h0000FFFC);
    alusrcb = 2'b11;
    step();
    check("imm_zext_sh2", adr, 32'h0003FFF0);
    iord   = 1'b0;
    immext = 1'b0;

    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);
    write_reg(5'd3, 32'd7);
    write_reg(5'd4, 32'h0000DEAD);
    write_reg(5'd5, 32'h40000010);

    // ALU ops with A=$1=5, B=$2=7
    alusrca = 1'b1;
    alusrcb = 2'b00;
    seti({6'd0, 5'd1, 5'd2, 16'd0});
    check("b_reg", writedata, 32'd7);
    alucontrol = 3'b110;
    #1;
    check("sub_zero0", {31'd0, zero}, 32'h0);
    step();
    iord = 1'b1;
    #1;
    check("sub_res", adr, 32'hFFFFFFFE);
    alucontrol = 3'b111;
    #1;
    check("slt_zero0", {31'd0, zero}, 32'h0);
    step();
    check("slt_res", adr, 32'h1);
    alucontrol = 3'b000;
    step();
    check("and_res", adr, 32'h5);
    alucontrol = 3'b001;
    step();
    check("or_res", adr, 32'h7);
    alucontrol = 3'b011;
    #1;
    check("bad_zero1", {31'd0, zero}, 32'h1);
    step();
    check("bad_res", adr, 32'h0);
    iord = 1'b0;

    // A=B=7 subtract gives zero
    seti({6'd0, 5'd3, 5'd2, 16'd0});
    alucontrol = 3'b110;
    #1;
    check("sub_eq_zero1", {31'd0, zero}, 32'h1);

    // ALUOut=DEAD written to $0 is discarded
    alucontrol = 3'b010;
    alusrcb    = 2'b10;
    seti({6'd0, 5'd4, 5'd0, 16'd0});
    step();
    iord = 1'b1;
    #1;
    check("aluout_dead", adr, 32'h0000DEAD);
    regwrite = 1'b1;
    regdst   = 1'b1;
    memtoreg = 1'b0;
    step();
    regwrite = 1'b0;
    step();
    check("r0_still0", writedata, 32'h0);

    // same write to $9: old value this cycle, new value next
    alusrcb = 2'b00;
    seti({6'd0, 5'd4, 5'd9, 5'd9, 11'd0});
    check("aluout_dead2", adr, 32'h0000DEAD);
    regwrite = 1'b1;
    step();
    regwrite = 1'b0;
    regdst   = 1'b0;
    check("r9_same_cyc", writedata, 32'h0);
    step();
    check("r9_next_cyc", writedata, 32'h0000DEAD);
`ifdef DATAPATH_DBG_EN
    check("dbg_r9", dbg_rd, 32'h0000DEAD);
`endif
    iord = 1'b0;

    // jump: PC=40000010, instr[25:0]=100 -> 40000400
    alusrca = 1'b1;
    alusrcb = 2'b10;
    seti({6'd0, 5'd5, 5'd0, 16'd0});
    pcen  = 1'b1;
    pcsrc = 2'b00;
    step();
    pcen = 1'b0;
    check("pc_load", adr, 32'h40000010);
    readdata = 32'h08000100;
    irwrite  = 1'b1;
    step();
    irwrite = 1'b0;
    check("j_opcode", {26'd0, opcode}, 32'h02);
    pcsrc = 2'b10;
    pcen  = 1'b1;
    step();
    pcen = 1'b0;
    check("jump_pc", adr, 32'h40000400);

    // $5 holds a value before the reset pulse
    pcsrc = 2'b00;
    seti({6'd0, 5'd0, 5'd5, 16'd0});
    check("r5_before", writedata, 32'h40000010);

    // asynchronous reset mid-cycle, with a write pending
    #3;
    reset    = 1'b1;
    regwrite = 1'b1;
    #1;
    check("arst_adr", adr, 32'h0);
    check("arst_opcode", {26'd0, opcode}, 32'h0);
    check("arst_wdata", writedata, 32'h0);
    step();
    reset    = 1'b0;
    regwrite = 1'b0;
    seti({6'd0, 5'd0, 5'd5, 16'd0});
    check("r5_after_rst", writedata, 32'h0);
    check("pc_after_rst", adr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
